demux_dispatch_ctrl: RTL and testbench
======================================

DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter DW, default 8, data width of din/dout.
REQ-002 Parameter TIMEOUT, default 4, stall cycles allowed on one channel before retargeting (legal 1..255).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 din  input  DW  source data word.
REQ-006 din_valid  input  1  source word present.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 dout  output  DW  shared data bus to all four sinks (held word).
REQ-009 dout_valid  output  4  one-hot; bit i = word offered to sink i.
REQ-010 dout_ready  input  4  bit i = sink i accepts this cycle.
REQ-011 sel  output  2  current target channel (round-robin pointer).
REQ-012 skip  output  1  one-cycle pulse when a channel is abandoned on timeout.

Function
REQ-013 The block SHALL be a two-state FSM: EMPTY (no held word) and FULL (one held word).
REQ-014 din_ready SHALL equal 1 in EMPTY and 0 in FULL; no combinational path from dout_ready to din_ready.
REQ-015 EMPTY with din_valid=1: the block SHALL latch din into dout and go to FULL on that edge.
REQ-016 FULL: dout_valid SHALL be one-hot at bit sel; in EMPTY dout_valid SHALL be 4'b0000.
REQ-017 FULL with dout_ready[sel]=1: transfer completes on that edge; state -> EMPTY; sel -> sel+1 mod 4 (3 wraps to 0).
REQ-018 dout_ready bits other than sel SHALL be ignored.
REQ-019 wait_cnt (8-bit internal) SHALL increment each FULL cycle with dout_ready[sel]=0 and clear on transfer or retarget.
REQ-020 FULL, dout_ready[sel]=0, wait_cnt==TIMEOUT-1: sel -> sel+1 mod 4, word retained, state stays FULL, skip=1 for that next cycle only.
REQ-021 Same cycle transfer and timeout: transfer SHALL win; no skip.
REQ-022 Minimum latency: din accepted at edge N, dout_valid high from N; throughput max one word per 2 cycles.
REQ-023 dout SHALL hold its value while FULL and keep last value in EMPTY.
REQ-024 The held word SHALL never be dropped except by reset.

Reset
REQ-025 rst_n=0 SHALL immediately force: state EMPTY, dout_valid 0, din_ready 1 after release, sel 0, skip 0, dout 0, wait_cnt 0.
REQ-026 Reset mid-transfer SHALL discard the held word; no dout_valid asserted until a new word is accepted.
REQ-027 First rising edge after rst_n deasserts SHALL be a normal operating edge.

Configuration
REQ-028 Macro DEMUX_DISPATCH_STATS_EN defined: output cnt_flat (32 bits) SHALL exist, four 8-bit delivered-word counters, channel i at bits [8i+7:8i], increment on each completed transfer to channel i, wrap 255->0, reset to 0.
REQ-029 Macro undefined: cnt_flat port and counters SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, then din=8'hA5, din_valid=1, all dout_ready=1 -> dout_valid 0001 then 0010, 0100, 1000, 0001 on successive words; sel 0,1,2,3,0.
REQ-031 FULL on sel=1, dout_ready=0000 for 4 cycles (TIMEOUT=4) -> skip pulse once, dout_valid 0010 -> 0100, dout unchanged.
REQ-032 sel=2, dout_ready[2] rises in the timeout cycle -> transfer, no skip, sel=3, state EMPTY.
REQ-033 dout_ready=1101 with sel=1 -> no transfer, held word stays on dout.
REQ-034 rst_n pulled low while FULL with 8'h3C held -> dout_valid 0 immediately, sel 0, din_ready 1 after release.
REQ-035 Stats build: 260 words to channel 0 only (others stalled) -> cnt_flat[7:0]=4.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl
//   Single-word holding buffer that offers its word to one of four sinks
//   at a time, rotating round-robin. If the targeted sink stalls for
//   TIMEOUT cycles, the word is retargeted to the next channel and skip
//   pulses for one cycle.
//
// Parameters
//   DW       data width of din/dout
//   TIMEOUT  stall cycles tolerated on one channel before retargeting (1..255)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din         source data word
//   din_valid   source word present
//   din_ready   block can accept a word this cycle (registered, high when empty)
//   dout        held word, shared by all sinks
//   dout_valid  one-hot offer; bit i = word offered to sink i
//   dout_ready  bit i = sink i accepts this cycle (only bit sel is used)
//   sel         current target channel
//   skip        one-cycle pulse after a channel is abandoned on timeout
//   cnt_flat    (only with DEMUX_DISPATCH_STATS_EN) four 8-bit delivered-word
//               counters, channel i at bits [8i+7:8i], wrapping
//
// Optional build macro: DEMUX_DISPATCH_STATS_EN

module demux_dispatch_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic [3:0]    dout_valid,
  input  logic [3:0]    dout_ready,
  output logic [1:0]    sel,
  output logic          skip
`ifdef DEMUX_DISPATCH_STATS_EN
  ,
  output logic [31:0]   cnt_flat
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [1:0] sel_nxt;
  logic       take;

  assign sel_nxt = sel + 2'd1;
  // Only the targeted sink's ready matters; other bits are ignored.
  assign take    = (state == FULL) && dout_ready[sel];

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      din_ready  <= 1'b1;
      dout       <= '0;
      dout_valid <= '0;
      sel        <= '0;
      skip       <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      skip <= 1'b0;
      case (state)
        EMPTY: begin
          if (din_valid) begin
            state      <= FULL;
            din_ready  <= 1'b0;
            dout       <= din;
            dout_valid <= onehot(sel);
            wait_cnt   <= '0;
          end
        end
        FULL: begin
          // Transfer takes priority over a coincident timeout.
          if (dout_ready[sel]) begin
            state      <= EMPTY;
            din_ready  <= 1'b1;
            dout_valid <= '0;
            sel        <= sel_nxt;
            wait_cnt   <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            sel        <= sel_nxt;
            dout_valid <= onehot(sel_nxt);
            wait_cnt   <= '0;
            skip       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state      <= EMPTY;
          din_ready  <= 1'b1;
          dout_valid <= '0;
        end
      endcase
    end
  end

`ifdef DEMUX_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_flat <= '0;
    end else if (take) begin
      cnt_flat[{sel, 3'b000} +: 8] <= cnt_flat[{sel, 3'b000} +: 8] + 8'd1;
    end
  end
`else
  logic unused_take;
  assign unused_take = take;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic [3:0] dout_valid;
  logic [3:0] dout_ready;
  logic [1:0] sel;
  logic       skip;
`ifdef DEMUX_DISPATCH_STATS_EN
  logic [31:0] cnt_flat;
`endif

  int checks   = 0;
  int failures = 0;

  demux_dispatch_ctrl #(.DW(8), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sel        (sel),
    .skip       (skip)
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    .cnt_flat   (cnt_flat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One active edge, then sample/drive on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = '0;
    step();
    check("rst_valid", {28'd0, dout_valid}, 32'h0);
    check("rst_sel",   {30'd0, sel},        32'h0);
    check("rst_skip",  {31'd0, skip},       32'h0);
    check("rst_dout",  {24'd0, dout},       32'h0);
    rst_n = 1'b1;
    check("rst_ready", {31'd0, din_ready},  32'h1);

    // Round-robin with all sinks ready
    din        = 8'hA5;
    din_valid  = 1'b1;
    dout_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_valid", {28'd0, dout_valid}, 32'h1 << (i % 4));
      check("rr_sel",   {30'd0, sel},        32'(i % 4));
      check("rr_dout",  {24'd0, dout},       32'hA5);
      check("rr_busy",  {31'd0, din_ready},  32'h0);
      step();
      check("rr_done",  {28'd0, dout_valid}, 32'h0);
      check("rr_next",  {30'd0, sel},        32'((i + 1) % 4));
    end

    // Timeout on sel=1
    din        = 8'h5A;
    dout_ready = 4'b0000;
    step();
    din_valid = 1'b0;
    check("to_valid0", {28'd0, dout_valid}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_hold",  {28'd0, dout_valid}, 32'h2);
      check("to_noskp", {31'd0, skip},       32'h0);
    end
    step();
    check("to_valid1", {28'd0, dout_valid}, 32'h4);
    check("to_sel",    {30'd0, sel},        32'h2);
    check("to_skip",   {31'd0, skip},       32'h1);
    check("to_dout",   {24'd0, dout},       32'h5A);
    step();
    check("to_skip1c", {31'd0, skip},       32'h0);
    check("to_valid2", {28'd0, dout_valid}, 32'h4);

    // Ready arrives in the timeout cycle on sel=2: transfer wins
    step();
    step();
    check("tw_pre", {28'd0, dout_valid}, 32'h4);
    dout_ready = 4'b0100;
    step();
    check("tw_valid", {28'd0, dout_valid}, 32'h0);
    check("tw_sel",   {30'd0, sel},        32'h3);
    check("tw_skip",  {31'd0, skip},       32'h0);
    check("tw_ready", {31'd0, din_ready},  32'h1);
    check("tw_dout",  {24'd0, dout},       32'h5A);

    // Advance to sel=1, then non-selected readys are ignored
    dout_ready = 4'b1111;
    din_valid  = 1'b1;
    din        = 8'h11;
    step(); step(); step(); step();
    check("adv_sel", {30'd0, sel}, 32'h1);
    din        = 8'hC3;
    dout_ready = 4'b1101;
    step();
    din_valid = 1'b0;
    step();
    step();
    check("ign_valid", {28'd0, dout_valid}, 32'h2);
    check("ign_dout",  {24'd0, dout},       32'hC3);
    check("ign_busy",  {31'd0, din_ready},  32'h0);
    dout_ready = 4'b0010;
    step();
    check("ign_xfer",  {30'd0, sel},        32'h2);

    // Reset while FULL
    din        = 8'h3C;
    din_valid  = 1'b1;
    dout_ready = 4'b0000;
    step();
    check("rm_dout", {24'd0, dout}, 32'h3C);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rm_valid", {28'd0, dout_valid}, 32'h0);
    check("rm_sel",   {30'd0, sel},        32'h0);
    check("rm_dout0", {24'd0, dout},       32'h0);
    step();
    rst_n = 1'b1;
    check("rm_ready", {31'd0, din_ready}, 32'h1);
    step();
    check("rm_novalid", {28'd0, dout_valid}, 32'h0);
    din       = 8'h77;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("rm_new", {28'd0, dout_valid}, 32'h1);
    check("rm_newd", {24'd0, dout},      32'h77);

`ifdef DEMUX_DISPATCH_STATS_EN
    begin
      int delivered = 0;
      int budget    = 0;
      rst_n = 1'b0;
      step();
      rst_n      = 1'b1;
      dout_ready = 4'b0001;
      din        = 8'h42;
      din_valid  = 1'b1;
      while (delivered < 260 && budget < 20000) begin
        step();
        budget++;
        if (dout_valid[0]) begin
          delivered++;
          if (delivered == 260) din_valid = 1'b0;
        end
      end
      check("st_budget", 32'(delivered), 32'd260);
      step();
      check("st_cnt", cnt_flat, 32'h0000_0004);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
